// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station slice.
//   OP_W, ROB_BIT, DAT_W : opcode, ROB tag and datapath widths
//   OP_*                 : opcode encodings used by dispatch and the ALU
//   rs_entry_t           : payload held by one reservation-station entry
package reservation_station_pkg;

   localparam int OP_W    = 5;
   localparam int ROB_BIT = 4;
   localparam int DAT_W   = 32;

   localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
   localparam logic [OP_W-1:0] OP_AND  = 5'd2;
   localparam logic [OP_W-1:0] OP_OR   = 5'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 5'd4;
   localparam logic [OP_W-1:0] OP_LUI  = 5'd5;
   localparam logic [OP_W-1:0] OP_BEQ  = 5'd6;
   localparam logic [OP_W-1:0] OP_JAL  = 5'd7;

   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic               ic;
      logic [ROB_BIT-1:0] qd;
      logic [DAT_W-1:0]   vs;
      logic [ROB_BIT-1:0] qs;
      logic               rdys;
      logic [DAT_W-1:0]   vt;
      logic [ROB_BIT-1:0] qt;
      logic               rdyt;
      logic [DAT_W-1:0]   imm;
      logic [DAT_W-1:0]   pc;
   } rs_entry_t;

endpackage

// File: rtl/reservation_station_prio_enc.sv
// Lowest-index-set priority encoder.
//   req   : request vector, bit 0 has highest priority
//   idx   : index of the lowest set bit (0 when none set)
//   found : at least one request bit is set
module rs_prio_enc #(
   parameter int N_BIT = 3,
   localparam int N    = 1 << N_BIT
) (
   input  logic [N-1:0]     req,
   output logic [N_BIT-1:0] idx,
   output logic             found
);

   // NOTE: every output gets a default before the loop so no path leaves it
   // unassigned; otherwise this combinational block would infer a latch.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      // Scan downwards so the last hit, i.e. the lowest index, wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = N_BIT'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Issue buffer between dispatch and the ALU.
//   clk, rst_n     : clock, synchronous active-low reset
//   en             : global stall, low freezes all state and outputs
//   clear_i        : flush on branch mispredict
//   dis_*          : dispatch of one decoded op with its operand state
//   cdb_*          : common data bus broadcast used for operand wakeup
//   full_o         : no free entry
//   alu_en_o/alu_* : registered issue of one fully-ready op per cycle
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int RS_BIT   = 3,
   localparam int RS_SIZE = 1 << RS_BIT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               clear_i,
   input  logic               dis_en_i,
   input  logic [OP_W-1:0]    dis_op_i,
   input  logic               dis_ic_i,
   input  logic [ROB_BIT-1:0] dis_qd_i,
   input  logic [DAT_W-1:0]   dis_vs_i,
   input  logic [ROB_BIT-1:0] dis_qs_i,
   input  logic               dis_rdys_i,
   input  logic [DAT_W-1:0]   dis_vt_i,
   input  logic [ROB_BIT-1:0] dis_qt_i,
   input  logic               dis_rdyt_i,
   input  logic [DAT_W-1:0]   dis_imm_i,
   input  logic [DAT_W-1:0]   dis_pc_i,
   input  logic               cdb_en_i,
   input  logic [ROB_BIT-1:0] cdb_q_i,
   input  logic [DAT_W-1:0]   cdb_v_i,
   output logic               full_o,
   output logic               alu_en_o,
   output logic [OP_W-1:0]    alu_op_o,
   output logic               alu_ic_o,
   output logic [ROB_BIT-1:0] alu_qd_o,
   output logic [DAT_W-1:0]   alu_vs_o,
   output logic [DAT_W-1:0]   alu_vt_o,
   output logic [DAT_W-1:0]   alu_imm_o,
   output logic [DAT_W-1:0]   alu_pc_o
);

   logic [RS_SIZE-1:0] busy;
   rs_entry_t          entries [RS_SIZE];
   rs_entry_t          new_entry;

   logic [RS_SIZE-1:0] free_vec;
   logic [RS_SIZE-1:0] ready_vec;
   logic [RS_BIT-1:0]  free_idx;
   logic [RS_BIT-1:0]  iss_idx;
   logic               free_found;
   logic               iss_found;

   always_comb begin
      free_vec  = ~busy;
      ready_vec = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         ready_vec[i] = busy[i] & entries[i].rdys & entries[i].rdyt;
      end
   end

   rs_prio_enc #(.N_BIT(RS_BIT)) u_free_sel (
      .req   (free_vec),
      .idx   (free_idx),
      .found (free_found)
   );

   rs_prio_enc #(.N_BIT(RS_BIT)) u_issue_sel (
      .req   (ready_vec),
      .idx   (iss_idx),
      .found (iss_found)
   );

   assign full_o = ~free_found;

   // Incoming op with a same-cycle CDB bypass applied to each waiting operand.
   always_comb begin
      new_entry = '{op: dis_op_i, ic: dis_ic_i, qd: dis_qd_i,
                    vs: dis_vs_i, qs: dis_qs_i, rdys: dis_rdys_i,
                    vt: dis_vt_i, qt: dis_qt_i, rdyt: dis_rdyt_i,
                    imm: dis_imm_i, pc: dis_pc_i};
      if (!dis_rdys_i && cdb_en_i && dis_qs_i == cdb_q_i) begin
         new_entry.vs   = cdb_v_i;
         new_entry.rdys = 1'b1;
      end
      if (!dis_rdyt_i && cdb_en_i && dis_qt_i == cdb_q_i) begin
         new_entry.vt   = cdb_v_i;
         new_entry.rdyt = 1'b1;
      end
   end

   // NOTE: all state here uses non-blocking assignments, so every read of
   // busy/entries sees the value from the start of the cycle. That is what
   // keeps issue, wakeup and allocation from seeing each other's updates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy      <= '0;
         alu_en_o  <= 1'b0;
         alu_op_o  <= '0;
         alu_ic_o  <= 1'b0;
         alu_qd_o  <= '0;
         alu_vs_o  <= '0;
         alu_vt_o  <= '0;
         alu_imm_o <= '0;
         alu_pc_o  <= '0;
      end else if (en) begin
         if (clear_i) begin
            busy     <= '0;
            alu_en_o <= 1'b0;
         end else begin
            alu_en_o <= iss_found;
            if (iss_found) begin
               alu_op_o      <= entries[iss_idx].op;
               alu_ic_o      <= entries[iss_idx].ic;
               alu_qd_o      <= entries[iss_idx].qd;
               alu_vs_o      <= entries[iss_idx].vs;
               alu_vt_o      <= entries[iss_idx].vt;
               alu_imm_o     <= entries[iss_idx].imm;
               alu_pc_o      <= entries[iss_idx].pc;
               busy[iss_idx] <= 1'b0;
            end

            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy[i] && cdb_en_i) begin
                  if (!entries[i].rdys && entries[i].qs == cdb_q_i) begin
                     entries[i].vs   <= cdb_v_i;
                     entries[i].rdys <= 1'b1;
                  end
                  if (!entries[i].rdyt && entries[i].qt == cdb_q_i) begin
                     entries[i].vt   <= cdb_v_i;
                     entries[i].rdyt <= 1'b1;
                  end
               end
            end

            // The free slot is never busy, so it cannot collide with the
            // issuing slot or with a wakeup write above.
            if (dis_en_i && free_found) begin
               entries[free_idx] <= new_entry;
               busy[free_idx]    <= 1'b1;
            end
         end
      end
   end
   // NOTE: entry payloads are deliberately not reset; busy alone marks them
   // valid, so clearing the storage would only add reset fan-out.

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station.
module tb_reservation_station;
   import reservation_station_pkg::*;

   logic               clk;
   logic               rst_n;
   logic               en;
   logic               clear_i;
   logic               dis_en_i;
   logic [OP_W-1:0]    dis_op_i;
   logic               dis_ic_i;
   logic [ROB_BIT-1:0] dis_qd_i;
   logic [DAT_W-1:0]   dis_vs_i;
   logic [ROB_BIT-1:0] dis_qs_i;
   logic               dis_rdys_i;
   logic [DAT_W-1:0]   dis_vt_i;
   logic [ROB_BIT-1:0] dis_qt_i;
   logic               dis_rdyt_i;
   logic [DAT_W-1:0]   dis_imm_i;
   logic [DAT_W-1:0]   dis_pc_i;
   logic               cdb_en_i;
   logic [ROB_BIT-1:0] cdb_q_i;
   logic [DAT_W-1:0]   cdb_v_i;
   logic               full_o;
   logic               alu_en_o;
   logic [OP_W-1:0]    alu_op_o;
   logic               alu_ic_o;
   logic [ROB_BIT-1:0] alu_qd_o;
   logic [DAT_W-1:0]   alu_vs_o;
   logic [DAT_W-1:0]   alu_vt_o;
   logic [DAT_W-1:0]   alu_imm_o;
   logic [DAT_W-1:0]   alu_pc_o;

   int passed = 0;
   int total  = 0;

   reservation_station dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clear_i    (clear_i),
      .dis_en_i   (dis_en_i),
      .dis_op_i   (dis_op_i),
      .dis_ic_i   (dis_ic_i),
      .dis_qd_i   (dis_qd_i),
      .dis_vs_i   (dis_vs_i),
      .dis_qs_i   (dis_qs_i),
      .dis_rdys_i (dis_rdys_i),
      .dis_vt_i   (dis_vt_i),
      .dis_qt_i   (dis_qt_i),
      .dis_rdyt_i (dis_rdyt_i),
      .dis_imm_i  (dis_imm_i),
      .dis_pc_i   (dis_pc_i),
      .cdb_en_i   (cdb_en_i),
      .cdb_q_i    (cdb_q_i),
      .cdb_v_i    (cdb_v_i),
      .full_o     (full_o),
      .alu_en_o   (alu_en_o),
      .alu_op_o   (alu_op_o),
      .alu_ic_o   (alu_ic_o),
      .alu_qd_o   (alu_qd_o),
      .alu_vs_o   (alu_vs_o),
      .alu_vt_o   (alu_vt_o),
      .alu_imm_o  (alu_imm_o),
      .alu_pc_o   (alu_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge; inputs are driven and outputs sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clear_i    = 1'b0;
      dis_en_i   = 1'b0;
      cdb_en_i   = 1'b0;
      cdb_q_i    = '0;
      cdb_v_i    = '0;
      dis_ic_i   = 1'b0;
      dis_imm_i  = '0;
      dis_pc_i   = '0;
   endtask

   task automatic drive_dis(input logic [OP_W-1:0] op, input logic [ROB_BIT-1:0] qd,
                            input logic [DAT_W-1:0] vs, input logic [ROB_BIT-1:0] qs,
                            input logic rdys, input logic [DAT_W-1:0] vt,
                            input logic [ROB_BIT-1:0] qt, input logic rdyt);
      dis_en_i   = 1'b1;
      dis_op_i   = op;
      dis_qd_i   = qd;
      dis_vs_i   = vs;
      dis_qs_i   = qs;
      dis_rdys_i = rdys;
      dis_vt_i   = vt;
      dis_qt_i   = qt;
      dis_rdyt_i = rdyt;
   endtask

   task automatic drive_cdb(input logic [ROB_BIT-1:0] q, input logic [DAT_W-1:0] v);
      cdb_en_i = 1'b1;
      cdb_q_i  = q;
      cdb_v_i  = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total++; if (alu_en_o !== 1'b0) $display("FAIL reset_en: got %0b want 0", alu_en_o); else passed++;
      total++; if (full_o !== 1'b0) $display("FAIL reset_full: got %0b want 0", full_o); else passed++;
      total++; if (alu_vs_o !== '0) $display("FAIL reset_vs: got %0h want 0", alu_vs_o); else passed++;
      total++; if (alu_qd_o !== '0) $display("FAIL reset_qd: got %0h want 0", alu_qd_o); else passed++;
      total++; if (alu_op_o !== '0) $display("FAIL reset_op: got %0h want 0", alu_op_o); else passed++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_ready_op();
      drive_dis(OP_ADD, 4'd5, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 1'b1);
      dis_ic_i  = 1'b1;
      dis_imm_i = 32'h11;
      dis_pc_i  = 32'h100;
      step();
      idle();
      total++; if (alu_en_o !== 1'b0) $display("FAIL ready_no_same_cycle: got %0b want 0", alu_en_o); else passed++;
      total++; if (full_o !== 1'b0) $display("FAIL ready_full: got %0b want 0", full_o); else passed++;
      step();
      total++; if (alu_en_o !== 1'b1) $display("FAIL ready_en: got %0b want 1", alu_en_o); else passed++;
      total++; if (alu_op_o !== OP_ADD) $display("FAIL ready_op: got %0h want %0h", alu_op_o, OP_ADD); else passed++;
      total++; if (alu_qd_o !== 4'd5) $display("FAIL ready_qd: got %0d want 5", alu_qd_o); else passed++;
      total++; if (alu_vs_o !== 32'd3) $display("FAIL ready_vs: got %0h want 3", alu_vs_o); else passed++;
      total++; if (alu_vt_o !== 32'd4) $display("FAIL ready_vt: got %0h want 4", alu_vt_o); else passed++;
      total++; if (alu_imm_o !== 32'h11) $display("FAIL ready_imm: got %0h want 11", alu_imm_o); else passed++;
      total++; if (alu_pc_o !== 32'h100) $display("FAIL ready_pc: got %0h want 100", alu_pc_o); else passed++;
      total++; if (alu_ic_o !== 1'b1) $display("FAIL ready_ic: got %0b want 1", alu_ic_o); else passed++;
      step();
      total++; if (alu_en_o !== 1'b0) $display("FAIL ready_en_drop: got %0b want 0", alu_en_o); else passed++;
      total++; if (alu_vs_o !== 32'd3) $display("FAIL ready_vs_hold: got %0h want 3", alu_vs_o); else passed++;
   endtask

   task automatic test_dependent();
      drive_dis(OP_SUB, 4'd6, 32'd0, 4'd2, 1'b0, 32'd9, 4'd0, 1'b1);
      step();
      idle();
      step();
      total++; if (alu_en_o !== 1'b0) $display("FAIL dep_waiting: got %0b want 0", alu_en_o); else passed++;
      drive_cdb(4'd3, 32'h55);
      step();
      idle();
      step();
      total++; if (alu_en_o !== 1'b0) $display("FAIL dep_wrong_tag: got %0b want 0", alu_en_o); else passed++;
      drive_cdb(4'd2, 32'h10);
      step();
      idle();
      total++; if (alu_en_o !== 1'b0) $display("FAIL dep_wakeup_edge: got %0b want 0", alu_en_o); else passed++;
      step();
      total++; if (alu_en_o !== 1'b1) $display("FAIL dep_en: got %0b want 1", alu_en_o); else passed++;
      total++; if (alu_vs_o !== 32'h10) $display("FAIL dep_vs: got %0h want 10", alu_vs_o); else passed++;
      total++; if (alu_vt_o !== 32'd9) $display("FAIL dep_vt: got %0h want 9", alu_vt_o); else passed++;
      total++; if (alu_op_o !== OP_SUB) $display("FAIL dep_op: got %0h want %0h", alu_op_o, OP_SUB); else passed++;
      total++; if (alu_qd_o !== 4'd6) $display("FAIL dep_qd: got %0d want 6", alu_qd_o); else passed++;
      step();
      total++; if (alu_en_o !== 1'b0) $display("FAIL dep_en_drop: got %0b want 0", alu_en_o); else passed++;
   endtask

   task automatic test_bypass();
      drive_dis(OP_XOR, 4'd8, 32'd1, 4'd0, 1'b1, 32'd0, 4'd7, 1'b0);
      drive_cdb(4'd7, 32'hAB);
      step();
      idle();
      total++; if (alu_en_o !== 1'b0) $display("FAIL byp_no_same_cycle: got %0b want 0", alu_en_o); else passed++;
      step();
      total++; if (alu_en_o !== 1'b1) $display("FAIL byp_en: got %0b want 1", alu_en_o); else passed++;
      total++; if (alu_vt_o !== 32'hAB) $display("FAIL byp_vt: got %0h want ab", alu_vt_o); else passed++;
      total++; if (alu_qd_o !== 4'd8) $display("FAIL byp_qd: got %0d want 8", alu_qd_o); else passed++;
      step();
   endtask

   task automatic test_fill_order();
      for (int i = 0; i < 8; i++) begin
         drive_dis(OP_AND, 4'(8 + i), 32'd0, 4'd1, 1'b0, 32'd5, 4'd0, 1'b1);
         step();
      end
      total++; if (full_o !== 1'b1) $display("FAIL fill_full: got %0b want 1", full_o); else passed++;
      // Ninth dispatch while full: must be dropped.
      drive_dis(OP_OR, 4'd3, 32'd0, 4'd1, 1'b0, 32'd5, 4'd0, 1'b1);
      step();
      idle();
      total++; if (full_o !== 1'b1) $display("FAIL fill_drop_full: got %0b want 1", full_o); else passed++;
      total++; if (alu_en_o !== 1'b0) $display("FAIL fill_drop_en: got %0b want 0", alu_en_o); else passed++;
      drive_cdb(4'd1, 32'h20);
      step();
      idle();
      total++; if (alu_en_o !== 1'b0) $display("FAIL fill_wakeup_edge: got %0b want 0", alu_en_o); else passed++;
      for (int k = 0; k < 8; k++) begin
         step();
         total++; if (alu_en_o !== 1'b1) $display("FAIL fill_en_%0d: got %0b want 1", k, alu_en_o); else passed++;
         total++; if (alu_qd_o !== 4'(8 + k)) $display("FAIL fill_qd_%0d: got %0d want %0d", k, alu_qd_o, 8 + k); else passed++;
         total++; if (alu_vs_o !== 32'h20) $display("FAIL fill_vs_%0d: got %0h want 20", k, alu_vs_o); else passed++;
         if (k == 0) begin
            total++; if (full_o !== 1'b0) $display("FAIL fill_full_drop: got %0b want 0", full_o); else passed++;
         end
      end
      step();
      total++; if (alu_en_o !== 1'b0) $display("FAIL fill_drained_en: got %0b want 0", alu_en_o); else passed++;
      total++; if (full_o !== 1'b0) $display("FAIL fill_drained_full: got %0b want 0", full_o); else passed++;
   endtask

   task automatic test_flush();
      drive_dis(OP_ADD, 4'd1, 32'd0, 4'd4, 1'b0, 32'd0, 4'd0, 1'b1);
      step();
      drive_dis(OP_ADD, 4'd2, 32'd0, 4'd4, 1'b0, 32'd0, 4'd0, 1'b1);
      step();
      drive_dis(OP_ADD, 4'd3, 32'hC, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1);
      step();
      // The ready op would issue on this edge; flush wins, and the
      // simultaneous dispatch is ignored.
      drive_dis(OP_SUB, 4'd4, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 1'b1);
      clear_i = 1'b1;
      step();
      idle();
      total++; if (alu_en_o !== 1'b0) $display("FAIL flush_en: got %0b want 0", alu_en_o); else passed++;
      total++; if (full_o !== 1'b0) $display("FAIL flush_full: got %0b want 0", full_o); else passed++;
      drive_cdb(4'd4, 32'h44);
      step();
      idle();
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (alu_en_o !== 1'b0) $display("FAIL flush_stale_%0d: got %0b want 0", k, alu_en_o); else passed++;
      end
   endtask

   task automatic test_stall_reset();
      drive_dis(OP_ADD, 4'd1, 32'h31, 4'd0, 1'b1, 32'd0, 4'd0, 1'b1);
      step();
      drive_dis(OP_ADD, 4'd9, 32'd0, 4'd5, 1'b0, 32'd0, 4'd0, 1'b1);
      step();
      idle();
      total++; if (alu_en_o !== 1'b1) $display("FAIL stall_pre_en: got %0b want 1", alu_en_o); else passed++;
      en = 1'b0;
      drive_cdb(4'd5, 32'h77);
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (alu_en_o !== 1'b1) $display("FAIL stall_en_%0d: got %0b want 1", k, alu_en_o); else passed++;
         total++; if (alu_qd_o !== 4'd1) $display("FAIL stall_qd_%0d: got %0d want 1", k, alu_qd_o); else passed++;
      end
      en = 1'b1;
      idle();
      step();
      total++; if (alu_en_o !== 1'b0) $display("FAIL stall_no_capture: got %0b want 0", alu_en_o); else passed++;
      drive_cdb(4'd5, 32'h66);
      step();
      idle();
      step();
      total++; if (alu_en_o !== 1'b1) $display("FAIL stall_wake_en: got %0b want 1", alu_en_o); else passed++;
      total++; if (alu_vs_o !== 32'h66) $display("FAIL stall_wake_vs: got %0h want 66", alu_vs_o); else passed++;
      total++; if (alu_qd_o !== 4'd9) $display("FAIL stall_wake_qd: got %0d want 9", alu_qd_o); else passed++;
      // Reset mid-stream discards a pending ready op.
      drive_dis(OP_OR, 4'd12, 32'h5, 4'd0, 1'b1, 32'h6, 4'd0, 1'b1);
      step();
      idle();
      rst_n = 1'b0;
      step();
      total++; if (alu_en_o !== 1'b0) $display("FAIL rst_mid_en: got %0b want 0", alu_en_o); else passed++;
      total++; if (alu_qd_o !== '0) $display("FAIL rst_mid_qd: got %0d want 0", alu_qd_o); else passed++;
      total++; if (full_o !== 1'b0) $display("FAIL rst_mid_full: got %0b want 0", full_o); else passed++;
      rst_n = 1'b1;
      step();
      step();
      total++; if (alu_en_o !== 1'b0) $display("FAIL rst_mid_discard: got %0b want 0", alu_en_o); else passed++;
   endtask

   initial begin
      rst_n      = 1'b0;
      en         = 1'b1;
      dis_op_i   = '0;
      dis_qd_i   = '0;
      dis_vs_i   = '0;
      dis_qs_i   = '0;
      dis_rdys_i = 1'b0;
      dis_vt_i   = '0;
      dis_qt_i   = '0;
      dis_rdyt_i = 1'b0;
      idle();
      test_reset();
      test_ready_op();
      test_dependent();
      test_bypass();
      test_fill_order();
      test_flush();
      test_stall_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
